// File: rtl/hls4ml_mul_acc_pipe_if.sv
// Beat/result bus of hls4ml_mul_acc_pipe: operand beats in, products or group sums out.
interface hls4ml_mul_acc_pipe_if #(
    parameter int A_WIDTH   = 11,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 24,
    parameter int CNT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_last;
    logic [A_WIDTH-1:0]   din0;
    logic [B_WIDTH-1:0]   din1;
    logic                 dout_valid;
    logic                 dout_last;
    logic [P_WIDTH-1:0]   dout;
    logic [CNT_WIDTH-1:0] beat_count;
    logic                 sat_flag;

    modport master (
        output in_valid, in_last, din0, din1,
        input  dout_valid, dout_last, dout, beat_count, sat_flag
    );

    modport slave (
        input  in_valid, in_last, din0, din1,
        output dout_valid, dout_last, dout, beat_count, sat_flag
    );
endinterface

// File: rtl/hls4ml_mul_acc_pipe.sv
// Pipelined signed multiplier with optional per-group accumulation and valid/last tracking.
// Optional output clamping and sticky sat_flag: define HLS4ML_MUL_SATURATE_EN.
module hls4ml_mul_acc_pipe #(
    parameter int A_WIDTH    = 11,
    parameter int B_WIDTH    = 16,
    parameter int P_WIDTH    = 24,
    parameter int NUM_STAGE  = 3,
    parameter int ACCUMULATE = 0,
    parameter int GUARD_BITS = 4,
    parameter int SHIFT      = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    hls4ml_mul_acc_pipe_if.slave bus
);
    localparam int          PROD_W = A_WIDTH + B_WIDTH;
    localparam int          ACC_W  = PROD_W + GUARD_BITS;
    localparam int unsigned PSTG   = NUM_STAGE - 2;

    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic                      v1_q, l1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v1_q <= 1'b0;
            l1_q <= 1'b0;
        end else if (ce) begin
            a_q  <= bus.din0;
            b_q  <= bus.din1;
            v1_q <= bus.in_valid;
            l1_q <= bus.in_last;
        end
    end

    logic signed [PROD_W-1:0] prod_c, prod_t;
    logic                     pv_t, pl_t;

    assign prod_c = PROD_W'(a_q) * PROD_W'(b_q);

    // With NUM_STAGE=2 the product feeds the next stage directly from the operand registers.
    if (PSTG > 0) begin : g_prod
        logic signed [PROD_W-1:0] p_q [PSTG];
        logic [PSTG-1:0]          pv_q, pl_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int unsigned i = 0; i < PSTG; i++) p_q[i] <= '0;
                pv_q <= '0;
                pl_q <= '0;
            end else if (ce) begin
                p_q[0]  <= prod_c;
                pv_q[0] <= v1_q;
                pl_q[0] <= l1_q;
                for (int unsigned i = 1; i < PSTG; i++) begin
                    p_q[i]  <= p_q[i-1];
                    pv_q[i] <= pv_q[i-1];
                    pl_q[i] <= pl_q[i-1];
                end
            end
        end

        assign prod_t = p_q[PSTG-1];
        assign pv_t   = pv_q[PSTG-1];
        assign pl_t   = pl_q[PSTG-1];
    end else begin : g_noprod
        assign prod_t = prod_c;
        assign pv_t   = v1_q;
        assign pl_t   = l1_q;
    end

    logic signed [ACC_W-1:0] prod_ext, res;
    logic                    res_v, res_l;
    logic [CNT_WIDTH-1:0]    res_cnt;

    assign prod_ext = ACC_W'(prod_t);

    if (ACCUMULATE != 0) begin : g_acc
        logic signed [ACC_W-1:0] acc_q, sum, sum_q;
        logic [CNT_WIDTH-1:0]    cnt_q, cnt_inc, cnt_out_q;
        logic                    sum_v_q;

        assign sum     = acc_q + prod_ext;
        assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

        // The closing beat's sum goes out while acc restarts at 0, so the next group needs no bubble.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_q     <= '0;
                cnt_q     <= '0;
                sum_q     <= '0;
                cnt_out_q <= '0;
                sum_v_q   <= 1'b0;
            end else if (ce) begin
                sum_v_q <= pv_t & pl_t;
                if (pv_t) begin
                    if (pl_t) begin
                        sum_q     <= sum;
                        cnt_out_q <= cnt_inc;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                    end else begin
                        acc_q <= sum;
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end

        assign res     = sum_q;
        assign res_v   = sum_v_q;
        assign res_l   = 1'b1;
        assign res_cnt = cnt_out_q;
    end else begin : g_noacc
        assign res     = prod_ext;
        assign res_v   = pv_t;
        assign res_l   = pl_t;
        assign res_cnt = CNT_WIDTH'(1);
    end

    logic [P_WIDTH-1:0] narrowed;

`ifdef HLS4ML_MUL_SATURATE_EN
    logic signed [ACC_W-1:0] shifted;
    logic [ACC_W-P_WIDTH:0]  hi;
    logic                    in_range;

    assign shifted  = res >>> SHIFT;
    assign hi       = shifted[ACC_W-1:P_WIDTH-1];
    assign in_range = (&hi) | ~(|hi);
    assign narrowed = in_range ? shifted[P_WIDTH-1:0]
                    : shifted[ACC_W-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                    : {1'b0, {(P_WIDTH-1){1'b1}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.sat_flag <= 1'b0;
        else if (ce && res_v && !in_range) bus.sat_flag <= 1'b1;
    end
`else
    assign narrowed     = P_WIDTH'(res >>> SHIFT);
    assign bus.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dout_valid <= 1'b0;
            bus.dout_last  <= 1'b0;
            bus.dout       <= '0;
            bus.beat_count <= '0;
        end else if (ce) begin
            bus.dout_valid <= res_v;
            if (res_v) begin
                bus.dout       <= narrowed;
                bus.dout_last  <= res_l;
                bus.beat_count <= res_cnt;
            end
        end
    end
endmodule

// File: tb/tb_hls4ml_mul_acc_pipe.sv
// Bench driving identical beats into a per-beat instance and an accumulating instance,
// checked against a queue-based reference model.
module tb_hls4ml_mul_acc_pipe;
    localparam int A_W   = 11;
    localparam int B_W   = 16;
    localparam int P_W   = 24;
    localparam int C_W   = 8;
    localparam int NS    = 3;
    localparam int SHIFT = 0;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    always #5 clk = ~clk;

    hls4ml_mul_acc_pipe_if #(.A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W), .CNT_WIDTH(C_W)) bus0 ();
    hls4ml_mul_acc_pipe_if #(.A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W), .CNT_WIDTH(C_W)) bus1 ();

    hls4ml_mul_acc_pipe #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W), .NUM_STAGE(NS),
        .ACCUMULATE(0), .GUARD_BITS(4), .SHIFT(SHIFT), .CNT_WIDTH(C_W)
    ) u_dut0 (.clk(clk), .reset(reset), .ce(ce), .bus(bus0));

    hls4ml_mul_acc_pipe #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W), .NUM_STAGE(NS),
        .ACCUMULATE(1), .GUARD_BITS(4), .SHIFT(SHIFT), .CNT_WIDTH(C_W)
    ) u_dut1 (.clk(clk), .reset(reset), .ce(ce), .bus(bus1));

    typedef struct {
        logic [23:0] dout;
        logic        last;
        logic [7:0]  cnt;
        int          due;
        bit          clamp;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     ce_cnt = 0;
    int     raw_cnt = 0;
    bit     ce_at_edge = 1'b0;
    bit     sat_exp0 = 1'b0;
    bit     sat_exp1 = 1'b0;
    int     last_raw0 = 0;
    longint acc_sum = 0;
    int     acc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic void narrow(input longint v, output logic [23:0] d, output bit c);
        longint t;
        t = v >>> SHIFT;
        d = t[23:0];
        c = 1'b0;
`ifdef HLS4ML_MUL_SATURATE_EN
        if (t > longint'(8388607)) begin
            d = 24'h7FFFFF;
            c = 1'b1;
        end else if (t < -longint'(8388608)) begin
            d = 24'h800000;
            c = 1'b1;
        end
`endif
    endfunction

    task automatic push_beat(input int a, input int b, input bit l);
        longint      p;
        logic [23:0] d;
        bit          c;
        exp_t        e;
        p = longint'(a) * longint'(b);
        narrow(p, d, c);
        e.dout = d; e.last = l; e.cnt = 8'd1; e.due = ce_cnt + NS; e.clamp = c;
        q0.push_back(e);
        acc_sum = acc_sum + p;
        acc_sum = (acc_sum <<< 33) >>> 33;
        acc_cnt = (acc_cnt < 255) ? acc_cnt + 1 : 255;
        if (l) begin
            narrow(acc_sum, d, c);
            e.dout = d; e.last = 1'b1; e.cnt = 8'(acc_cnt); e.due = ce_cnt + NS + 1; e.clamp = c;
            q1.push_back(e);
            acc_sum = 0;
            acc_cnt = 0;
        end
    endtask

    task automatic beat(input int a, input int b, input bit v, input bit l);
        bus0.in_valid = v; bus0.in_last = l; bus0.din0 = A_W'(a); bus0.din1 = B_W'(b);
        bus1.in_valid = v; bus1.in_last = l; bus1.din0 = A_W'(a); bus1.din1 = B_W'(b);
        if (ce && v && !reset) push_beat(a, b, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(0, 0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string when);
        chk({when, ".dut0.dout_valid"}, 64'(bus0.dout_valid), 64'(0));
        chk({when, ".dut0.dout"},       64'(bus0.dout),       64'(0));
        chk({when, ".dut0.dout_last"},  64'(bus0.dout_last),  64'(0));
        chk({when, ".dut0.beat_count"}, 64'(bus0.beat_count), 64'(0));
        chk({when, ".dut0.sat_flag"},   64'(bus0.sat_flag),   64'(0));
        chk({when, ".dut1.dout_valid"}, 64'(bus1.dout_valid), 64'(0));
        chk({when, ".dut1.dout"},       64'(bus1.dout),       64'(0));
        chk({when, ".dut1.dout_last"},  64'(bus1.dout_last),  64'(0));
        chk({when, ".dut1.beat_count"}, 64'(bus1.beat_count), 64'(0));
        chk({when, ".dut1.sat_flag"},   64'(bus1.sat_flag),   64'(0));
    endtask

    task automatic pop_check(input int id, input logic [23:0] d, input logic l,
                             input logic [7:0] c, input logic s);
        exp_t  e;
        int    qs;
        string p;
        p  = (id == 0) ? "dut0" : "dut1";
        qs = (id == 0) ? q0.size() : q1.size();
        vectors++;
        assert (qs != 0) else begin
            miscompares++;
            $error("FAIL %s.spurious: observed dout_valid=1 dout=%0h expected no result", p, d);
        end
        if (qs != 0) begin
            if (id == 0) begin
                e = q0.pop_front();
                sat_exp0 |= e.clamp;
                last_raw0 = raw_cnt;
                chk({p, ".sat_flag"}, 64'(s), 64'(sat_exp0));
            end else begin
                e = q1.pop_front();
                sat_exp1 |= e.clamp;
                chk({p, ".sat_flag"}, 64'(s), 64'(sat_exp1));
            end
            chk({p, ".dout"},       64'(d),      64'(e.dout));
            chk({p, ".dout_last"},  64'(l),      64'(e.last));
            chk({p, ".beat_count"}, 64'(c),      64'(e.cnt));
            chk({p, ".latency"},    64'(ce_cnt), 64'(e.due));
        end
    endtask

    always @(posedge clk) begin
        raw_cnt++;
        if (ce) ce_cnt++;
        ce_at_edge = ce;
    end

    always @(negedge clk) begin
        if (!reset && ce_at_edge) begin
            if (bus0.dout_valid) pop_check(0, bus0.dout, bus0.dout_last, bus0.beat_count, bus0.sat_flag);
            if (bus1.dout_valid) pop_check(1, bus1.dout, bus1.dout_last, bus1.beat_count, bus1.sat_flag);
        end
    end

    initial begin
        int raw_start;
        reset = 1'b1;
        ce    = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_last = 1'b0; bus0.din0 = '0; bus0.din1 = '0;
        bus1.in_valid = 1'b0; bus1.in_last = 1'b0; bus1.din0 = '0; bus1.din1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        idle(2);

        // Single beat and back-to-back beats
        beat(-5, 7, 1'b1, 1'b1);
        idle(5);
        beat(1, 1, 1'b1, 1'b1);
        beat(2, 2, 1'b1, 1'b1);
        beat(3, 3, 1'b1, 1'b1);
        idle(5);

        // Groups: three-beat group then a single-beat group with no gap
        beat(2, 3, 1'b1, 1'b0);
        beat(4, 5, 1'b1, 1'b0);
        beat(-1, 6, 1'b1, 1'b1);
        beat(7, 1, 1'b1, 1'b1);
        idle(5);

        // Bubble inside a group, with a stray in_last on the invalid cycle
        beat(3, 3, 1'b1, 1'b0);
        beat(9, 9, 1'b0, 1'b1);
        beat(2, 2, 1'b1, 1'b1);
        idle(5);

        // Positive and negative overflow of the output range
        beat(-1024, -32768, 1'b1, 1'b1);
        beat(-1024, 32767, 1'b1, 1'b1);
        idle(5);

        // ce stall mid-pipeline, then a stall while a result is being presented
        raw_start = raw_cnt;
        beat(-5, 7, 1'b1, 1'b1);
        ce = 1'b0;
        beat(3, 3, 1'b1, 1'b1);
        beat(3, 3, 1'b1, 1'b1);
        ce = 1'b1;
        idle(2);
        ce = 1'b0;
        @(posedge clk);
        #1;
        chk("stall.hold.dout_valid", 64'(bus0.dout_valid), 64'(1));
        chk("stall.hold.dout", 64'(bus0.dout), 64'(24'hFFFFDD));
        ce = 1'b1;
        idle(4);
        chk("stall.arrival_edge", 64'(last_raw0), 64'(raw_start + 5));

        // beat_count saturation over a 300-beat group
        for (int i = 0; i < 299; i++) beat(1, 1, 1'b1, 1'b0);
        beat(1, 1, 1'b1, 1'b1);
        idle(6);

        // Reset in the middle of a group discards the partial sum
        beat(10, 10, 1'b1, 1'b0);
        beat(10, 10, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_zero("midreset");
        q0.delete();
        q1.delete();
        acc_sum  = 0;
        acc_cnt  = 0;
        sat_exp0 = 1'b0;
        sat_exp1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        beat(3, 3, 1'b1, 1'b1);
        idle(2);

        for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        #1;
        chk("dut0.pending_results", 64'(q0.size()), 64'(0));
        chk("dut1.pending_results", 64'(q1.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hls4ml_mul_acc_pipe.md
Name: hls4ml_mul_acc_pipe

Overview:
Parametrised pipelined signed multiplier with optional multiply-accumulate mode and valid/last tracking. It is the next-generation replacement for the fixed-width 3-stage DSP48 multiplier wrappers emitted per layer. Widths, latency, output scaling and accumulation are set at elaboration. Sits in dense/conv layer datapaths, where it consumes weight × activation beats and produces either per-beat products or per-group dot-product sums.

Parameters:
A_WIDTH, 11, signed width of din0
B_WIDTH, 16, signed width of din1
P_WIDTH, 24, signed width of dout
NUM_STAGE, 3, multiply pipeline depth in ce-cycles; legal range 2..6
ACCUMULATE, 0, 0 = per-beat product; 1 = accumulate beats until in_last
GUARD_BITS, 4, extra accumulator bits; ACC_WIDTH = A_WIDTH+B_WIDTH+GUARD_BITS
SHIFT, 0, arithmetic right shift applied before output narrowing; legal range 0..ACC_WIDTH-P_WIDTH
CNT_WIDTH, 8, width of beat_count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
ce  in  1  global clock enable; 0 freezes every register
in_valid  in  1  din0/din1/in_last are valid this cycle
in_last  in  1  final beat of an accumulation group (pass-through when ACCUMULATE=0)
din0  in  A_WIDTH  signed operand A
din1  in  B_WIDTH  signed operand B
dout_valid  out  1  dout is valid; asserted for exactly one ce-cycle per result
dout_last  out  1  last flag aligned with dout
dout  out  P_WIDTH  signed result
beat_count  out  CNT_WIDTH  number of beats in the group just output; saturates at all-ones
sat_flag  out  1  sticky saturation indicator; tied 0 when the optional feature is absent

Behaviour:
- Reset (asynchronous): clears all valid bits, the accumulator, the beat counter, dout, dout_last, beat_count and sat_flag to 0. Any partial group is discarded.
- ce=0: no register changes and inputs are not sampled. in_valid during ce=0 is lost, and the upstream logic must hold it. Outputs hold their values. dout_valid stays at its current value but represents the same single result.
- Stage 1 registers din0, din1, in_valid and in_last. Stages 2..NUM_STAGE-1 carry the full-width product a*b (A_WIDTH+B_WIDTH bits, signed) with valid/last. The final stage registers the narrowed output.
- ACCUMULATE=0:
  - Every accepted beat produces one result NUM_STAGE ce-cycles later.
  - dout_last = in_last of that beat.
  - beat_count = 1.
- ACCUMULATE=1:
  - One accumulator stage is inserted before the output stage, so latency is NUM_STAGE+1 ce-cycles from the in_last beat.
  - A valid product with last=0 adds into acc (sign-extended to ACC_WIDTH) and produces no output.
  - A valid product with last=1 outputs narrow(acc+product), asserts dout_valid with dout_last=1, and the accumulator restarts at 0 for the next beat (no bubble).
  - A single-beat group (first beat has in_last=1) outputs that product alone.
  - beat_count holds the beats in the group.
  - in_last with in_valid=0 is ignored.
- Bubbles (in_valid=0 with ce=1) propagate as invalid stages and do not disturb the accumulator.
- Narrowing:
  - t = value >>> SHIFT (arithmetic, truncate toward -inf).
  - Without the optional feature, dout = t[P_WIDTH-1:0] and overflow wraps.
- ACC_WIDTH overflow wraps silently. GUARD_BITS is sized by the user for 2^GUARD_BITS beats per group.
- Throughput: one beat per ce-cycle sustained in both modes.

Optional Feature:
- Macro: HLS4ML_MUL_SATURATE_EN.
- Defined: if t exceeds the P_WIDTH signed range, dout clamps to 2^(P_WIDTH-1)-1 or -2^(P_WIDTH-1), and sat_flag sets on that output cycle and stays set until reset.
- Undefined: wrap as above, and sat_flag is constant 0.
- Clamp logic is absent from synthesis when the macro is undefined.

Test Plan:
- Defaults, ce=1, din0=-5, din1=7, in_valid=1 for one cycle -> exactly 3 cycles later dout=0xFFFFDD (-35), dout_valid=1 for one cycle, beat_count=1.
- Defaults, back-to-back beats (1×1, 2×2, 3×3) -> dout 1, 4, 9 on three consecutive cycles starting at cycle 3.
- ACCUMULATE=1, beats (2,3), (4,5), (-1,6, in_last=1), then immediately (7,1, in_last=1) -> dout=20 with beat_count=3, then next cycle dout=7 with beat_count=1; no output on the non-last beats.
- Saturation: din0=-1024, din1=-32768 -> with macro, dout=0x7FFFFF and sat_flag=1 (sticky); without macro, dout=0x000000 and sat_flag=0.
- ce stall: beat -5×7 accepted, then ce=0 for 2 cycles mid-pipeline -> dout=-35 appears at cycle 5 instead of 3; dout_valid counts as one result.
- Reset mid-group (ACCUMULATE=1): two non-last beats 10×10, assert reset, then a single beat 3×3 with in_last -> dout=9, beat_count=1; all outputs read 0 during reset.
